// File: rtl/cla16_bist.sv
// cla16_bist: self-test engine for a 16-bit CLA adder. It drives vectors, compares the responses
// with a golden sum and reports mismatches. Define CLA16_BIST_MISR_EN to add a 32-bit response signature.
module cla16_bist #(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter int unsigned DUT_LATENCY = 0,
    parameter logic [32:0] SEED        = 33'h1_2345_6789
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] dut_in1,
    output logic [15:0] dut_in2,
    output logic        dut_cin,
    input  logic [15:0] dut_sum,
    input  logic        dut_cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] fail_idx,
    output logic [16:0] fail_got
`ifdef CLA16_BIST_MISR_EN
    ,
    output logic [31:0] signature
`endif
);
    localparam int unsigned DEPTH      = DUT_LATENCY + 1;
    localparam int unsigned TAIL       = DEPTH - 1;
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DUT_LATENCY);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [15:0] idx_reg, drain_reg;
    logic [32:0] lfsr_reg, lfsr_next, vec_next;
    logic [16:0] exp_next, got;
    logic [15:0] err_count_reg, fail_idx_reg;
    logic [16:0] fail_got_reg;
    logic        first_reg, pass_reg;
    logic        start_run, cmp_vld, mismatch;

    // Expected result, vector index and valid bit travel together to the compare point
    logic [16:0] pipe_exp [DEPTH];
    logic [15:0] pipe_idx [DEPTH];
    logic        pipe_vld [DEPTH];

    // Fixed corner vectors packed as {cin, B, A}, matching the LFSR layout
    function automatic logic [32:0] corner_vec(input logic [2:0] i);
        case (i)
            3'd0:    corner_vec = {1'b0, 16'h0000, 16'h0000};
            3'd1:    corner_vec = {1'b0, 16'h0001, 16'hFFFF};
            3'd2:    corner_vec = {1'b1, 16'h0000, 16'hFFFF};
            3'd3:    corner_vec = {1'b1, 16'hFFFF, 16'hFFFF};
            3'd4:    corner_vec = {1'b0, 16'h8000, 16'h8000};
            3'd5:    corner_vec = {1'b1, 16'hAAAA, 16'h5555};
            3'd6:    corner_vec = {1'b1, 16'h1E78, 16'h030C};
            default: corner_vec = {1'b0, 16'h0011, 16'h000C};
        endcase
    endfunction

    assign start_run = (state_reg == IDLE) && start;
    assign vec_next  = (idx_reg < 16'd8) ? corner_vec(idx_reg[2:0]) : lfsr_reg;
    assign lfsr_next = {lfsr_reg[31:0], lfsr_reg[32] ^ lfsr_reg[19]};
    assign exp_next  = {1'b0, vec_next[15:0]} + {1'b0, vec_next[31:16]} + 17'(vec_next[32]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DRAIN;
            DRAIN:   if (drain_reg == DRAIN_LAST) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            drain_reg <= '0;
            lfsr_reg  <= SEED;
            dut_in1   <= '0;
            dut_in2   <= '0;
            dut_cin   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        idx_reg  <= '0;
                        lfsr_reg <= SEED;
                    end
                end
                RUN: begin
                    {dut_cin, dut_in2, dut_in1} <= vec_next;
                    idx_reg   <= idx_reg + 16'd1;
                    drain_reg <= '0;
                    if (idx_reg >= 16'd8) lfsr_reg <= lfsr_next;
                end
                DRAIN: drain_reg <= drain_reg + 16'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_exp[0] <= '0;
            pipe_idx[0] <= '0;
            pipe_vld[0] <= 1'b0;
        end else begin
            pipe_exp[0] <= exp_next;
            pipe_idx[0] <= idx_reg;
            pipe_vld[0] <= (state_reg == RUN);
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_pipe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_exp[gi] <= '0;
                    pipe_idx[gi] <= '0;
                    pipe_vld[gi] <= 1'b0;
                end else begin
                    pipe_exp[gi] <= pipe_exp[gi-1];
                    pipe_idx[gi] <= pipe_idx[gi-1];
                    pipe_vld[gi] <= pipe_vld[gi-1];
                end
            end
        end
    endgenerate

    assign got      = {dut_cout, dut_sum};
    assign cmp_vld  = pipe_vld[TAIL];
    assign mismatch = cmp_vld && (got != pipe_exp[TAIL]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_reg <= '0;
            fail_idx_reg  <= '0;
            fail_got_reg  <= '0;
            first_reg     <= 1'b0;
            pass_reg      <= 1'b0;
        end else if (start_run) begin
            err_count_reg <= '0;
            fail_idx_reg  <= '0;
            fail_got_reg  <= '0;
            first_reg     <= 1'b0;
            pass_reg      <= 1'b0;
        end else begin
            if (mismatch) begin
                if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
                if (!first_reg) begin
                    first_reg    <= 1'b1;
                    fail_idx_reg <= pipe_idx[TAIL];
                    fail_got_reg <= got;
                end
            end
            if (state_reg == DONE) pass_reg <= (err_count_reg == 16'd0);
        end
    end

    // The final compare lands on the edge entering DONE, so pass is taken live during that cycle
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    assign pass      = done ? (err_count_reg == 16'd0) : pass_reg;
    assign err_count = err_count_reg;
    assign fail_idx  = fail_idx_reg;
    assign fail_got  = fail_got_reg;

`ifdef CLA16_BIST_MISR_EN
    localparam logic [31:0] MISR_POLY = 32'h0040_0007;
    logic [31:0] misr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr_reg <= 32'hFFFF_FFFF;
        end else if (start_run) begin
            misr_reg <= 32'hFFFF_FFFF;
        end else if (cmp_vld) begin
            misr_reg <= {misr_reg[30:0], 1'b0} ^ (misr_reg[31] ? MISR_POLY : 32'h0) ^ {15'b0, got};
        end
    end

    assign signature = misr_reg;
`endif

endmodule

// File: tb/tb_cla16_bist.sv
// Randomized self-checking bench for cla16_bist: a corner-only unit (8 vectors, combinational adder)
// and a pipelined unit (100 vectors, 2-cycle adder) checked against a behavioural run model.
module tb_cla16_bist;
    localparam int NV_A  = 8;
    localparam int LAT_A = 0;
    localparam int NV_B  = 100;
    localparam int LAT_B = 2;
    localparam logic [32:0] SEED = 33'h1_2345_6789;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] in1_a, in2_a, in1_b, in2_b, sum_a, sum_b;
    logic        cin_a, cin_b, cout_a, cout_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] err_a, err_b, fidx_a, fidx_b;
    logic [16:0] fgot_a, fgot_b;
`ifdef CLA16_BIST_MISR_EN
    logic [31:0] sig_a, sig_b;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mode_v [2];
    int          fbit    = 0;
    logic [3:0]  fnib    = 4'h0;
    logic [16:0] pipe1, pipe2;

    logic [15:0] ca [8];
    logic [15:0] cb [8];
    logic        cc [8];
    logic [32:0] rand_vec [NV_B];

    always #5 clk = ~clk;

    cla16_bist #(.NUM_VECTORS(NV_A), .DUT_LATENCY(LAT_A), .SEED(SEED)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .dut_in1(in1_a), .dut_in2(in2_a), .dut_cin(cin_a),
        .dut_sum(sum_a), .dut_cout(cout_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_idx(fidx_a), .fail_got(fgot_a)
`ifdef CLA16_BIST_MISR_EN
        , .signature(sig_a)
`endif
    );

    cla16_bist #(.NUM_VECTORS(NV_B), .DUT_LATENCY(LAT_B), .SEED(SEED)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .dut_in1(in1_b), .dut_in2(in2_b), .dut_cin(cin_b),
        .dut_sum(sum_b), .dut_cout(cout_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_idx(fidx_b), .fail_got(fgot_b)
`ifdef CLA16_BIST_MISR_EN
        , .signature(sig_b)
`endif
    );

    // Adder under test: ideal sum with an optional injected fault
    function automatic logic [16:0] adder_model(input logic [15:0] a, input logic [15:0] b,
                                                input logic c, input int mode);
        logic [16:0] r;
        r = 17'(a) + 17'(b) + 17'(c);
        case (mode)
            1: r[0] = 1'b0;
            2: r[16] = 1'b1;
            3: if (a[3:0] == fnib) r[fbit] = ~r[fbit];
            default: ;
        endcase
        return r;
    endfunction

    always_comb {cout_a, sum_a} = adder_model(in1_a, in2_a, cin_a, mode_v[0]);

    always_ff @(posedge clk) begin
        pipe1 <= adder_model(in1_b, in2_b, cin_b, mode_v[1]);
        pipe2 <= pipe1;
    end
    assign {cout_b, sum_b} = pipe2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_vectors();
        bit          s [NV_B + 33];
        logic [32:0] seed_v;
        seed_v = SEED;
        ca = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h5555, 16'h030C, 16'h000C};
        cb = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h8000, 16'hAAAA, 16'h1E78, 16'h0011};
        cc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        // Generator as a bit stream, oldest bit first: s[n+33] = s[n] ^ s[n+13]
        for (int j = 0; j < 33; j++) s[j] = seed_v[32-j];
        for (int t = 0; t < NV_B; t++) s[t+33] = s[t] ^ s[t+13];
        for (int t = 0; t < NV_B; t++)
            for (int k = 0; k < 33; k++) rand_vec[t][k] = s[t+32-k];
    endtask

    task automatic compute_ref(input int nv, input int mode, output logic [15:0] e_err,
                               output logic [15:0] e_idx, output logic [16:0] e_got);
        logic [15:0] a, b;
        logic        c, found;
        logic [16:0] ideal, obs;
        e_err = 0; e_idx = 0; e_got = 0; found = 0;
        for (int i = 0; i < nv; i++) begin
            if (i < 8) begin
                a = ca[i]; b = cb[i]; c = cc[i];
            end else begin
                {c, b, a} = rand_vec[i-8];
            end
            ideal = 17'(a) + 17'(b) + 17'(c);
            obs   = adder_model(a, b, c, mode);
            if (obs != ideal) begin
                if (e_err != 16'hFFFF) e_err++;
                if (!found) begin
                    found = 1; e_idx = 16'(i); e_got = obs;
                end
            end
        end
    endtask

    function automatic logic busy_of(input int u);
        return (u == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic done_of(input int u);
        return (u == 0) ? done_a : done_b;
    endfunction
    function automatic logic pass_of(input int u);
        return (u == 0) ? pass_a : pass_b;
    endfunction

    task automatic set_start(input int u, input logic v);
        if (u == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic run_unit(input int u, input int mode);
        int          nv, lat, cyc, guard;
        logic [15:0] e_err, e_idx;
        logic [16:0] e_got;
        nv = (u == 0) ? NV_A : NV_B;
        lat = (u == 0) ? LAT_A : LAT_B;
        mode_v[u] = mode;
        compute_ref(nv, mode, e_err, e_idx, e_got);
        @(negedge clk) set_start(u, 1'b1);
        @(negedge clk) set_start(u, 1'b0);
        check("busy_rise", busy_of(u), 1);
        cyc = 0;
        guard = 0;
        while (!done_of(u) && guard < 2000) begin
            if (busy_of(u)) cyc++;
            guard++;
            set_start(u, guard == 10);
            @(negedge clk);
        end
        set_start(u, 1'b0);
        check("done_seen", done_of(u), 1);
        check("busy_cycles", cyc, nv + lat + 1);
        check("busy_in_done", busy_of(u), 0);
        check("pass", pass_of(u), e_err == 0);
        check("err_count", (u == 0) ? err_a : err_b, e_err);
        check("fail_idx", (u == 0) ? fidx_a : fidx_b, e_idx);
        check("fail_got", (u == 0) ? fgot_a : fgot_b, e_got);
        $display("[TB] run unit=%0d mode=%0d fbit=%0d fnib=%h busy=%0d err=%0d idx=%0d got=%h",
                 u, mode, fbit, fnib, cyc, e_err, e_idx, e_got);
        set_start(u, 1'b1);
        @(negedge clk) set_start(u, 1'b0);
        check("done_one_cycle", done_of(u), 0);
        check("start_in_done_ignored", busy_of(u), 0);
        check("pass_held", pass_of(u), e_err == 0);
        @(negedge clk);
        check("idle_after_done", busy_of(u), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, {busy_a, busy_b}, 0);
        check({tag, "_done"}, {done_a, done_b}, 0);
        check({tag, "_pass"}, {pass_a, pass_b}, 0);
        check({tag, "_err"}, {err_a, err_b}, 0);
        check({tag, "_fidx"}, {fidx_a, fidx_b}, 0);
        check({tag, "_fgot"}, {fgot_a, fgot_b}, 0);
        check({tag, "_vec_b"}, {cin_b, in2_b, in1_b}, 0);
        check({tag, "_vec_a"}, {cin_a, in2_a, in1_a}, 0);
    endtask

    initial begin
        int          wait_n, dones;
        mode_v[0] = 0;
        mode_v[1] = 0;
        build_vectors();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        run_unit(0, 0);
        run_unit(0, 1);
        run_unit(0, 2);
        run_unit(1, 0);
        run_unit(1, 2);
        run_unit(1, 1);

        for (int n = 0; n < 6; n++) begin
            fbit = $urandom_range(0, 16);
            fnib = 4'($urandom_range(0, 15));
            run_unit(n % 2, 3);
        end

        // Abort a run part-way through with reset
        mode_v[1] = 0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        wait_n = $urandom_range(20, 80);
        repeat (wait_n) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("midrun_reset");
        $display("[TB] reset asserted after %0d run cycles", wait_n);
        @(negedge clk) rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done_b || done_a || busy_b) dones++;
        end
        check("no_done_after_abort", dones, 0);
        run_unit(1, 0);

`ifdef CLA16_BIST_MISR_EN
        begin
            logic [31:0] s1, s2;
            run_unit(1, 0);
            s1 = sig_b;
            run_unit(1, 0);
            s2 = sig_b;
            check("sig_repeatable", s2 == s1, 1);
            fnib = 4'h5;
            fbit = $urandom_range(0, 16);
            run_unit(1, 3);
            check("sig_differs_on_error", sig_b != s1, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
